fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter in the write clock domain of the asynchronous FIFO.
- Shares the single FIFO write port among NUM_REQ producers, each using a valid/ready handshake.
- Drives the FIFO's w_en and data_in and stalls on the FIFO's full flag.
- Grants are bursty: a winner holds the port for up to MAX_BURST beats, then the grant rotates.

Parameters:
NUM_REQ, 4, number of requesters; must be >= 2.
DATA_WIDTH, 8, FIFO data width in bits.
MAX_BURST, 4, maximum beats per grant; must be >= 1.

Ports:
wclk  input  1  write-domain clock; all logic on posedge.
wrst_n  input  1  asynchronous active-low reset.
req_valid  input  NUM_REQ  per-requester data-valid.
req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
req_ready  output  NUM_REQ  per-requester accept; a beat transfers when valid and ready are both high.
fifo_full  input  1  FIFO full flag, wclk domain.
w_en  output  1  FIFO write enable.
data_in  output  DATA_WIDTH  FIFO write data.
grant_valid  output  1  high while in BURST.
grant_id  output  $clog2(NUM_REQ)  index of the current or last granted requester.

Behaviour:
- Reset (wrst_n low, asynchronous):
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0.
  - Combinational outputs therefore settle to w_en=0, req_ready=0, data_in=0, grant_valid=0.
- State machine, states IDLE and BURST, all registers updated on posedge wclk.
- IDLE:
  - Search req_valid starting at index rr_ptr, ascending with wrap modulo NUM_REQ.
  - If any bit is set, grant_id <= first set index, beat_cnt <= 0, next state BURST.
  - Otherwise stay in IDLE.
  - No transfers occur in IDLE. Latency from req_valid rising to the first write is 1 cycle.
- BURST (g = grant_id):
  - xfer = req_valid[g] & !fifo_full.
  - req_ready[g] = xfer. All other req_ready bits are 0.
  - w_en = xfer.
  - data_in = req_data[g] in BURST; data_in = 0 in IDLE.
  - On xfer, beat_cnt increments.
  - Exit to IDLE with rr_ptr <= (g+1) mod NUM_REQ when either:
    - xfer and beat_cnt == MAX_BURST-1, or
    - req_valid[g] == 0. This is an early release; no transfer occurs that cycle.
  - One IDLE bubble cycle always separates consecutive grants, including when the same requester wins again.
- Full handling:
  - fifo_full high in BURST means no transfer and no beat_cnt change; the grant is held.
  - There is no timeout.
  - If fifo_full and !req_valid[g] occur together, early release takes effect.
- Fairness:
  - Each requester is served within (NUM_REQ-1) grants after it raises valid.
  - rr_ptr changes only on BURST exit.
- Requester rules:
  - A requester must hold req_valid and req_data stable until the beat is accepted.
  - Dropping valid ends its grant.
- Widths:
  - beat_cnt is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST-1 while in BURST.
  - rr_ptr wraps from NUM_REQ-1 to 0.
- Reset mid-burst:
  - Outputs drop immediately (asynchronous).
  - The accepted beat count is lost; a partial burst is not resumed.
- Invariants:
  - At most one req_ready bit is high in any cycle.
  - w_en is never high while fifo_full is high.

Test Plan:
- Reset, then req_valid=4'b0100 with data 8'hA0..A3, fifo_full=0:
  - IDLE for 1 cycle, then grant_id=2 and 4 consecutive w_en beats writing A0,A1,A2,A3.
  - Then IDLE with rr_ptr=3.
- All four requesters continuously valid:
  - Grant order 0,1,2,3,0.
  - Each grant is 4 beats followed by 1 bubble, so 16 writes in 20 cycles.
- Requester 1 granted, fifo_full asserted after 2 beats for 5 cycles:
  - w_en=0 and req_ready=0 during the stall; grant_id stays 1.
  - Beats 3 and 4 are written after full drops.
- Requester 0 drops valid after 1 beat while requester 3 is waiting:
  - Release after that 1 beat, then IDLE, then grant_id=3 (search starts at rr_ptr=1).
- wrst_n pulsed low mid-burst at beat 2:
  - w_en, req_ready and grant_valid go 0 immediately.
  - After release: rr_ptr=0, and arbitration restarts from requester 0.
- Random valid and full stimulus for 10k cycles:
  - Scoreboard checks that per-requester write order matches the order accepted, with no duplicate or lost beats.
  - Checks at most one ready bit high and no w_en while fifo_full is high.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the producers, the arbiter and the FIFO write side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          w_en;
  logic [DATA_WIDTH-1:0]         data_in;
  logic                          grant_valid;
  logic [IDW-1:0]                grant_id;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, w_en, data_in, grant_valid, grant_id
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, w_en, data_in, grant_valid, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-granting arbiter sharing one async-FIFO write port.
//   state | meaning
//   IDLE  | no owner; search req_valid from rr_ptr for the next winner
//   BURST | grant_id owns the port for up to MAX_BURST beats
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic               wclk,
  input  logic               wrst_n,
  fifo_wr_arbiter_if.slave   bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;

  logic                  found;
  logic [IDW-1:0]        win_id;
  logic [IDW-1:0]        cand;
  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [IDW-1:0]        next_ptr;
  logic                  xfer;
  logic [NUM_REQ-1:0]    ready_c;
  logic [DATA_WIDTH-1:0] data_c;
  logic                  grant_valid_c;

  always_comb begin
    found  = 1'b0;
    win_id = '0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = bus.req_valid[grant_id_q];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IDW'(i)) sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    next_ptr = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    beat_cnt_d    = beat_cnt_q;
    xfer          = 1'b0;
    ready_c       = '0;
    data_c        = '0;
    grant_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_id_d = win_id;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        grant_valid_c       = 1'b1;
        data_c              = sel_data;
        xfer                = sel_valid & ~bus.fifo_full;
        ready_c[grant_id_q] = xfer;
        // Dropping valid releases the port even while the FIFO is full.
        if (!sel_valid || (xfer && beat_cnt_q == BCW'(MAX_BURST - 1))) begin
          state_d    = IDLE;
          rr_ptr_d   = next_ptr;
          beat_cnt_d = '0;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.req_ready   = ready_c;
  assign bus.w_en        = xfer;
  assign bus.data_in     = data_c;
  assign bus.grant_valid = grant_valid_c;
  assign bus.grant_id    = grant_id_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic against an owner/pointer model.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic wclk = 1'b0;
  logic wrst_n;
  always #5 wclk = ~wclk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus();

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [N-1:0] vld;
  logic         full;
  logic [7:0]   base [N];
  int           seq  [N];
  int           wseq [N];
  logic [7:0]   wr_log [$];
  int           gid_log [$];

  // Model: current owner (-1 = none), beats used, search start, last granted id
  int m_owner, m_beats, m_ptr, m_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] data_of(input int i);
    return base[i] | 8'(seq[i] % 64);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_ptr   = 0;
    m_last  = 0;
  endtask

  task automatic model_step();
    bit hit;
    int idx;
    if (m_owner < 0) begin
      hit = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!hit && vld[idx]) begin
          hit     = 1;
          m_owner = idx;
          m_last  = idx;
          m_beats = 0;
        end
      end
    end else if (!vld[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else if (!full) begin
      m_beats++;
      if (m_beats == MB) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  task automatic apply();
    bus.req_valid = vld;
    bus.fifo_full = full;
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = data_of(i);
  endtask

  // One clock: check outputs against the model, then advance model and requesters at posedge.
  task automatic tick();
    logic [N-1:0] er;
    logic [N-1:0] acc;
    logic [7:0]   ed;
    int           g;
    apply();
    #1;
    er = '0;
    ed = '0;
    if (m_owner >= 0) begin
      ed = data_of(m_owner);
      if (vld[m_owner] && !full) er[m_owner] = 1'b1;
    end
    chk("grant_valid", bus.grant_valid, m_owner >= 0);
    chk("grant_id", bus.grant_id, m_last);
    chk("req_ready", bus.req_ready, er);
    chk("w_en", bus.w_en, |er);
    chk("data_in", bus.data_in, ed);
    chk("ready_onehot", $countones(bus.req_ready) <= 1, 1);
    chk("wen_while_full", bus.w_en && bus.fifo_full, 0);
    if (bus.w_en) begin
      g = int'(bus.grant_id);
      wr_log.push_back(bus.data_in);
      gid_log.push_back(g);
      chk("sb_order", bus.data_in, base[g] | 8'(wseq[g] % 64));
      wseq[g]++;
    end
    acc = bus.req_valid & bus.req_ready;
    @(posedge wclk);
    if (wrst_n) model_step();
    for (int i = 0; i < N; i++) if (acc[i]) seq[i]++;
    @(negedge wclk);
  endtask

  task automatic new_scenario();
    wrst_n = 1'b0;
    vld    = '0;
    full   = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) begin
      seq[i]  = 0;
      wseq[i] = 0;
      base[i] = '0;
    end
    wr_log.delete();
    gid_log.delete();
    apply();
    @(negedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  initial begin
    wrst_n = 1'b1;
    vld    = '0;
    full   = 1'b0;
    for (int i = 0; i < N; i++) begin
      seq[i] = 0; wseq[i] = 0; base[i] = '0;
    end
    model_reset();
    apply();
    #2 wrst_n = 1'b0;
    #1;
    chk("rst_w_en", bus.w_en, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_data", bus.data_in, 0);
    chk("rst_gv", bus.grant_valid, 0);
    chk("rst_gid", bus.grant_id, 0);
    @(negedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;

    // Single requester 2: one bubble then A0..A3, pointer moves to 3
    new_scenario();
    base[2] = 8'hA0;
    vld = 4'b0100;
    repeat (5) tick();
    vld = 4'b0000;
    tick();
    chk("s1_nwr", wr_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("s1_data", wr_log[k], 8'hA0 + 8'(k));
      chk("s1_gid", gid_log[k], 2);
    end
    vld = 4'b1001;
    tick();
    chk("s1_ptr_gid", bus.grant_id, 3);
    chk("s1_ptr_gv", bus.grant_valid, 1);
    vld = '0;
    repeat (2) tick();

    // All valid: 0,1,2,3 bursts of 4 with bubbles, then wraps to 0
    new_scenario();
    for (int i = 0; i < N; i++) base[i] = 8'(16 * i);
    vld = 4'b1111;
    repeat (20) tick();
    chk("s2_nwr", wr_log.size(), 16);
    for (int k = 0; k < 4; k++) begin
      chk("s2_gid", gid_log[4*k], k);
      chk("s2_first", wr_log[4*k], 8'(16 * k));
    end
    tick();
    chk("s2_wrap_gid", bus.grant_id, 0);
    chk("s2_wrap_gv", bus.grant_valid, 1);
    vld = '0;
    repeat (2) tick();

    // Requester 1 stalled by full after 2 beats
    new_scenario();
    base[1] = 8'h50;
    vld = 4'b0010;
    repeat (3) tick();
    full = 1'b1;
    repeat (5) begin
      apply();
      #1;
      chk("s3_stall_wen", bus.w_en, 0);
      chk("s3_stall_rdy", bus.req_ready, 0);
      chk("s3_stall_gid", bus.grant_id, 1);
      tick();
    end
    full = 1'b0;
    repeat (3) tick();
    vld = '0;
    repeat (2) tick();
    chk("s3_nwr", wr_log.size(), 4);
    for (int k = 0; k < 4; k++) chk("s3_data", wr_log[k], 8'h50 + 8'(k));

    // Requester 0 drops after 1 beat; requester 3 wins next
    new_scenario();
    base[0] = 8'h60;
    base[3] = 8'h90;
    vld = 4'b1001;
    repeat (2) tick();
    vld = 4'b1000;
    repeat (2) tick();
    chk("s4_gid", bus.grant_id, 3);
    chk("s4_gv", bus.grant_valid, 1);
    chk("s4_nwr", wr_log.size(), 1);
    vld = '0;
    repeat (2) tick();

    // Reset mid-burst at beat 2 of requester 1 clears the pointer
    new_scenario();
    base[0] = 8'h20;
    base[1] = 8'h40;
    vld = 4'b0011;
    repeat (8) tick();
    apply();
    #1;
    chk("s5_pre_wen", bus.w_en, 1);
    chk("s5_pre_gid", bus.grant_id, 1);
    #2 wrst_n = 1'b0;
    #1;
    chk("s5_rst_wen", bus.w_en, 0);
    chk("s5_rst_rdy", bus.req_ready, 0);
    chk("s5_rst_gv", bus.grant_valid, 0);
    model_reset();
    @(posedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    vld = 4'b0101;
    repeat (2) tick();
    chk("s5_restart_gid", bus.grant_id, 0);
    chk("s5_restart_gv", bus.grant_valid, 1);
    vld = '0;
    repeat (2) tick();

    // Random valid/full traffic
    new_scenario();
    for (int i = 0; i < N; i++) base[i] = 8'(i << 6);
    repeat (10000) begin
      for (int i = 0; i < N; i++) begin
        if (!vld[i]) begin
          if ($urandom_range(3) == 0) vld[i] = 1'b1;
        end else if ($urandom_range(15) == 0) begin
          vld[i] = 1'b0;
        end
      end
      full = ($urandom_range(3) == 0);
      tick();
    end
    vld  = '0;
    full = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < N; i++) chk("rand_count", wseq[i], seq[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
